// File: rtl/snes_pad_poller.sv
// snes_pad_poller: polls NUM_PADS NES/SNES pads on a shared latch/clock and publishes active-high button frames
// Optional macro PAD_PRESS_EVENTS_EN adds per-bit new-press pulses on pressed; without it pressed is tied to 0.
// Ports: clk_50/reset (sync, active-high), poll_en (continuous polling), pad_dout (active-low serial data per pad),
//        pad_clk/pad_latch (shared pad strobes), buttons (pad p bit k at [p*NUM_BITS+k]), pressed (new-press pulses),
//        updated (pulse when buttons take a new frame), busy (LATCH entry to WAIT exit).
module snes_pad_poller #(
  parameter int NUM_PADS      = 2,
  parameter int NUM_BITS      = 16,
  parameter int HALF_PERIOD   = 300,
  parameter int LATCH_CYCLES  = 600,
  parameter int POLL_INTERVAL = 30000
) (
  input  logic                         clk_50,
  input  logic                         reset,
  input  logic                         poll_en,
  input  logic [NUM_PADS-1:0]          pad_dout,
  output logic                         pad_clk,
  output logic                         pad_latch,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic                         updated,
  output logic                         busy
);
  localparam int MAXP = LATCH_CYCLES > HALF_PERIOD
                      ? (LATCH_CYCLES > POLL_INTERVAL ? LATCH_CYCLES : POLL_INTERVAL)
                      : (HALF_PERIOD > POLL_INTERVAL ? HALF_PERIOD : POLL_INTERVAL);
  localparam int TW = MAXP > 1 ? $clog2(MAXP) : 1;
  localparam int BW = NUM_BITS > 1 ? $clog2(NUM_BITS) : 1;
  localparam logic [TW-1:0] T_LATCH = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_POLL = TW'(POLL_INTERVAL - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
  if (NUM_PADS < 1 || NUM_BITS < 1 || NUM_BITS > 32 || HALF_PERIOD < 1 ||
      LATCH_CYCLES < 1 || POLL_INTERVAL < 1) begin : g_bad_params
    $error("snes_pad_poller: parameters must be >= 1 and NUM_BITS <= 32");
  end
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP, S_LOW, S_HIGH, S_DONE, S_WAIT} state_t;
  typedef logic [NUM_PADS-1:0][NUM_BITS-1:0] frame_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_q, bit_d, cap_idx;
  frame_t shift_q, shift_d, buttons_q, buttons_d;
  logic pad_clk_q, pad_clk_d, pad_latch_q, pad_latch_d, updated_q, updated_d, busy_q, busy_d;
  logic cap, tdone;
  always_comb begin
    state_d = state_q;
    tdone = timer_q == '0;
    timer_d = tdone ? '0 : timer_q - 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    buttons_d = buttons_q;
    updated_d = 1'b0;
    cap = 1'b0;
    cap_idx = '0;
    case (state_q)
      S_IDLE: if (poll_en) begin
        state_d = S_LATCH;
        timer_d = T_LATCH;
      end
      S_LATCH: if (tdone) begin
        state_d = S_GAP;
        timer_d = T_HALF;
      end
      S_GAP: if (tdone) begin
        state_d = S_LOW;
        timer_d = T_HALF;
        bit_d = '0;
        cap = 1'b1;
      end
      S_LOW: if (tdone) begin
        state_d = S_HIGH;
        timer_d = T_HALF;
      end
      S_HIGH: if (tdone) begin
        if (bit_q == LAST_BIT) state_d = S_DONE;
        else begin
          state_d = S_LOW;
          timer_d = T_HALF;
          bit_d = bit_q + 1'b1;
          cap = 1'b1;
          cap_idx = bit_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_WAIT;
        timer_d = T_POLL;
        buttons_d = shift_q;
        updated_d = 1'b1;
      end
      S_WAIT: if (tdone) begin
        state_d = poll_en ? S_LATCH : S_IDLE;
        timer_d = poll_en ? T_LATCH : '0;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        bit_d = '0;
      end
    endcase
    // Sample every pad on the same edge that drives pad_clk low, before the pad's next rising-edge shift.
    if (cap) for (int p = 0; p < NUM_PADS; p++) shift_d[p][cap_idx] = ~pad_dout[p];
    pad_clk_d = state_d != S_LOW;
    pad_latch_d = state_d == S_LATCH;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      buttons_q <= '0;
      pad_clk_q <= 1'b1;
      pad_latch_q <= 1'b0;
      updated_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      buttons_q <= buttons_d;
      pad_clk_q <= pad_clk_d;
      pad_latch_q <= pad_latch_d;
      updated_q <= updated_d;
      busy_q <= busy_d;
    end
  end
`ifdef PAD_PRESS_EVENTS_EN
  frame_t pressed_q, pressed_d;
  always_comb pressed_d = state_q == S_DONE ? shift_q & ~buttons_q : '0;
  always_ff @(posedge clk_50) begin
    if (reset) pressed_q <= '0;
    else pressed_q <= pressed_d;
  end
  assign pressed = pressed_q;
`else
  assign pressed = '0;
`endif
  assign pad_clk = pad_clk_q;
  assign pad_latch = pad_latch_q;
  assign buttons = buttons_q;
  assign updated = updated_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_snes_pad_poller.sv
// tb_snes_pad_poller: directed bench for snes_pad_poller with two modelled 8-bit pads
module tb_snes_pad_poller;
  logic clk_50 = 1'b0;
  logic reset = 1'b1;
  logic poll_en = 1'b0;
  logic [1:0] pad_dout;
  logic pad_clk, pad_latch, updated, busy;
  logic [15:0] buttons, pressed;
  logic [7:0] pv0 = 8'hFF, pv1 = 8'hFF, sr0 = 8'hFF, sr1 = 8'hFF;
  int vecs = 0;
  int errs = 0;
`ifdef PAD_PRESS_EVENTS_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  snes_pad_poller #(
    .NUM_PADS(2), .NUM_BITS(8), .HALF_PERIOD(4), .LATCH_CYCLES(8), .POLL_INTERVAL(20)
  ) dut (
    .clk_50(clk_50), .reset(reset), .poll_en(poll_en), .pad_dout(pad_dout),
    .pad_clk(pad_clk), .pad_latch(pad_latch), .buttons(buttons), .pressed(pressed),
    .updated(updated), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  // Pad model: parallel load on latch, bit 0 presented first, shift on each pad_clk rise.
  always @(posedge pad_latch) begin
    sr0 <= pv0;
    sr1 <= pv1;
  end
  always @(posedge pad_clk) begin
    sr0 <= {1'b1, sr0[7:1]};
    sr1 <= {1'b1, sr1[7:1]};
  end
  assign pad_dout = {sr1[0], sr0[0]};

  task automatic tick;
    @(negedge clk_50);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    poll_en = 1'b0;
    repeat (3) tick;
    vecs++;
    if ({pad_clk, pad_latch, updated, busy} !== 4'b1000) begin
      errs++;
      $display("FAIL reset_ctrl: clk/latch/upd/busy got %b want 1000", {pad_clk, pad_latch, updated, busy});
    end
    vecs++;
    if (buttons !== 16'h0 || pressed !== 16'h0) begin
      errs++;
      $display("FAIL reset_data: buttons %h pressed %h want 0000 0000", buttons, pressed);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_frame;
    int latch_n = 0, low_n = 0, falls = 0, upd = 0, cyc = 0;
    logic pc = 1'b1;
    pv0 = 8'hFE;
    pv1 = 8'hFF;
    poll_en = 1'b1;
    while (cyc < 300 && upd == 0) begin
      tick;
      cyc++;
      if (pad_latch) latch_n++;
      if (!pad_clk) low_n++;
      if (pc && !pad_clk) falls++;
      pc = pad_clk;
      if (updated) upd++;
    end
    vecs++;
    if (upd != 1) begin errs++; $display("FAIL frame1_updated: seen %0d want 1 (timeout)", upd); end
    vecs++;
    if (latch_n != 8) begin errs++; $display("FAIL frame1_latch_len: got %0d want 8", latch_n); end
    vecs++;
    if (falls != 8) begin errs++; $display("FAIL frame1_clk_pulses: got %0d want 8", falls); end
    vecs++;
    if (low_n != 32) begin errs++; $display("FAIL frame1_clk_low_cycles: got %0d want 32", low_n); end
    vecs++;
    if (buttons !== 16'h0001) begin errs++; $display("FAIL frame1_buttons: got %h want 0001", buttons); end
    tick;
    vecs++;
    if (updated !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL frame1_pulse_width: updated %b busy %b want 0 1", updated, busy);
    end
  endtask

  task automatic test_no_partial;
    int bad = 0, cyc = 0;
    bit seen = 0;
    pv0 = 8'h5A;
    pv1 = 8'hA5;
    while (cyc < 300 && !seen) begin
      tick;
      cyc++;
      if (updated) seen = 1;
      else if (buttons !== 16'h0001) bad++;
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL frame2_updated: not seen within 300 cycles"); end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL frame2_partial: %0d cycles with buttons changed early, want 0", bad); end
    vecs++;
    if (buttons !== 16'h5AA5) begin errs++; $display("FAIL frame2_buttons: got %h want 5aa5", buttons); end
  endtask

  task automatic test_period;
    int edges[3];
    int n = 0, cyc = 0;
    logic pl = pad_latch;
    while (cyc < 400 && n < 3) begin
      tick;
      cyc++;
      if (!pl && pad_latch) begin
        edges[n] = cyc;
        n++;
      end
      pl = pad_latch;
    end
    vecs++;
    if (n != 3) begin errs++; $display("FAIL period_edges: got %0d rising edges want 3", n); end
    vecs++;
    if (edges[1] - edges[0] != 97) begin errs++; $display("FAIL period_1: got %0d want 97", edges[1] - edges[0]); end
    vecs++;
    if (edges[2] - edges[1] != 97) begin errs++; $display("FAIL period_2: got %0d want 97", edges[2] - edges[1]); end
  endtask

  task automatic test_poll_drop;
    int cyc = 0, falls = 0, latch_n = 0;
    bit rose = 0, seen = 0;
    logic pl = pad_latch, pc = pad_clk;
    pv0 = 8'h0F;
    pv1 = 8'hF0;
    while (cyc < 300 && !rose) begin
      tick;
      cyc++;
      if (!pl && pad_latch) rose = 1;
      pl = pad_latch;
    end
    while (cyc < 400 && falls < 3) begin
      tick;
      cyc++;
      if (pc && !pad_clk) falls++;
      pc = pad_clk;
    end
    poll_en = 1'b0;
    while (cyc < 600 && !seen) begin
      tick;
      cyc++;
      if (updated) seen = 1;
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL drop_updated: not seen after poll_en drop"); end
    vecs++;
    if (buttons !== 16'h0FF0) begin errs++; $display("FAIL drop_buttons: got %h want 0ff0", buttons); end
    repeat (19) tick;
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL drop_wait_end: busy %b want 1", busy); end
    tick;
    vecs++;
    if ({busy, pad_clk, pad_latch} !== 3'b010) begin
      errs++;
      $display("FAIL drop_idle: busy/clk/latch %b want 010", {busy, pad_clk, pad_latch});
    end
    repeat (150) begin
      tick;
      if (pad_latch || busy) latch_n++;
    end
    vecs++;
    if (latch_n != 0) begin errs++; $display("FAIL drop_stays_idle: %0d active cycles want 0", latch_n); end
  endtask

  task automatic test_reset_mid;
    int cyc = 0, falls = 0;
    bit rose = 0;
    logic pl = pad_latch, pc = pad_clk;
    poll_en = 1'b1;
    while (cyc < 300 && !rose) begin
      tick;
      cyc++;
      if (!pl && pad_latch) rose = 1;
      pl = pad_latch;
    end
    while (cyc < 400 && falls < 4) begin
      tick;
      cyc++;
      if (pc && !pad_clk) falls++;
      pc = pad_clk;
    end
    vecs++;
    if (falls != 4 || pad_clk !== 1'b0 || buttons !== 16'h0FF0) begin
      errs++;
      $display("FAIL midreset_pre: falls %0d clk %b buttons %h want 4 0 0ff0", falls, pad_clk, buttons);
    end
    reset = 1'b1;
    tick;
    vecs++;
    if ({pad_clk, pad_latch, busy, updated} !== 4'b1000 || buttons !== 16'h0) begin
      errs++;
      $display("FAIL midreset_post: clk/latch/busy/upd %b buttons %h want 1000 0000",
               {pad_clk, pad_latch, busy, updated}, buttons);
    end
    poll_en = 1'b0;
    tick;
  endtask

  task automatic test_press_events;
    pv0 = 8'hFD;
    pv1 = 8'hFF;
    reset = 1'b0;
    poll_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int cyc = 0, pn = 0;
      bit seen = 0;
      logic [15:0] pval = 16'h0;
      logic [15:0] exp_p = (f == 0 && PE) ? 16'h0002 : 16'h0000;
      while (cyc < 300 && !seen) begin
        tick;
        cyc++;
        if (pressed !== 16'h0) begin
          pn++;
          pval |= pressed;
        end
        if (updated) seen = 1;
      end
      vecs++;
      if (!seen || buttons !== 16'h0002) begin
        errs++;
        $display("FAIL press_frame%0d_buttons: seen %0d buttons %h want 1 0002", f, seen, buttons);
      end
      vecs++;
      if (pval !== exp_p || pn != (exp_p != 0 ? 1 : 0)) begin
        errs++;
        $display("FAIL press_frame%0d_pulse: value %h cycles %0d want %h %0d", f, pval, pn, exp_p, exp_p != 0 ? 1 : 0);
      end
      tick;
      vecs++;
      if (pressed !== 16'h0) begin errs++; $display("FAIL press_frame%0d_clear: got %h want 0000", f, pressed); end
    end
    poll_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_no_partial;
    test_period;
    test_poll_drop;
    test_reset_mid;
    test_press_events;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
